// File: rtl/cmos_pkg.sv
// Shared definitions for the OV7670 capture path (cmos_pixel_packer and cmos_geom_check).
// Contents: capture FSM state enum, default sensor geometry, counter widths.
package cmos_pkg;

  typedef enum logic [1:0] {
    StWaitInit = 2'd0,
    StWaitVs   = 2'd1,
    StSkip     = 2'd2,
    StActive   = 2'd3
  } cmos_state_e;

  localparam int unsigned DefHActive    = 640;
  localparam int unsigned DefVActive    = 480;
  localparam int unsigned DefSkipFrames = 10;

  localparam int unsigned PxCntW    = 12;
  localparam int unsigned LineCntW  = 12;
  localparam int unsigned SkipCntW  = 8;
  localparam int unsigned FrameCntW = 8;

endpackage

// File: rtl/cmos_geom_check.sv
// Line/frame geometry checker for the capture path.
// Ports:
//   clk, rst      pixel clock, asynchronous active-high reset
//   clr_i         init lost: clears counters and the sticky error
//   active_i      capture FSM is in the active-frame state
//   word_i        a 16-bit word is formed this cycle
//   line_end_i    href falling edge; the byte processed this cycle is the last of the line
//   odd_i         the last byte of the line opens a pair that never closes
//   frame_end_i   vsync rise that ends the active frame
//   geom_err_o    sticky geometry error
module cmos_geom_check
  import cmos_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned V_ACTIVE = DefVActive
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic active_i,
  input  logic word_i,
  input  logic line_end_i,
  input  logic odd_i,
  input  logic frame_end_i,
  output logic geom_err_o
);

  logic [PxCntW-1:0]   px_cnt_q, px_cnt_d, px_cnt_inc;
  logic [LineCntW-1:0] line_cnt_q, line_cnt_d;
  logic                err_q, err_d;

  always_comb begin
    px_cnt_inc = px_cnt_q + PxCntW'(word_i);
    px_cnt_d   = px_cnt_q;
    line_cnt_d = line_cnt_q;
    err_d      = err_q;
    if (clr_i) begin
      px_cnt_d   = '0;
      line_cnt_d = '0;
      err_d      = 1'b0;
    end else if (!active_i) begin
      px_cnt_d   = '0;
      line_cnt_d = '0;
    end else begin
      px_cnt_d = px_cnt_inc;
      if (line_end_i) begin
        // Include the word completed on the line's final byte.
        px_cnt_d   = '0;
        line_cnt_d = line_cnt_q + LineCntW'(1);
        if ((px_cnt_inc != PxCntW'(H_ACTIVE)) || odd_i) begin
          err_d = 1'b1;
        end
      end
      if (frame_end_i && (line_cnt_q != LineCntW'(V_ACTIVE))) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_cnt_q   <= '0;
      line_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      px_cnt_q   <= px_cnt_d;
      line_cnt_q <= line_cnt_d;
      err_q      <= err_d;
    end
  end

  assign geom_err_o = err_q;

endmodule

// File: rtl/cmos_pixel_packer.sv
// OV7670 capture stage: waits for init, discards settling frames, packs byte pairs into
// RGB565 words for the SDRAM write FIFO and reports frame validity.
// Optional geometry checking is built when CMOS_FRAME_CHECK_EN is defined; otherwise
// geom_err is tied low.
// Ports:
//   clk          sensor pixel clock (only clock)
//   rst          asynchronous active-high reset
//   init_done    sensor config and SDRAM init both complete
//   cmos_vsync   high = vertical blanking
//   cmos_href    high = active line bytes
//   cmos_data    sensor byte bus
//   pix_we       one-cycle write strobe for pix_data
//   pix_data     RGB565 word, first byte of the pair in [15:8]
//   frame_valid  high while the current frame is captured
//   frame_cnt    captured-frame counter, wraps
//   geom_err     sticky geometry error (0 when checking is not built)
module cmos_pixel_packer
  import cmos_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DefHActive,
  parameter int unsigned V_ACTIVE    = DefVActive,
  parameter int unsigned SKIP_FRAMES = DefSkipFrames
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_done,
  input  logic                 cmos_vsync,
  input  logic                 cmos_href,
  input  logic [7:0]           cmos_data,
  output logic                 pix_we,
  output logic [15:0]          pix_data,
  output logic                 frame_valid,
  output logic [FrameCntW-1:0] frame_cnt,
  output logic                 geom_err
);

  // Reject geometries the counters cannot represent.
  if (H_ACTIVE >= 2 ** PxCntW) begin : g_h_too_big
    $error("H_ACTIVE does not fit the pixel counter");
  end
  if (V_ACTIVE >= 2 ** LineCntW) begin : g_v_too_big
    $error("V_ACTIVE does not fit the line counter");
  end
  if (SKIP_FRAMES >= 2 ** SkipCntW) begin : g_skip_too_big
    $error("SKIP_FRAMES does not fit the skip counter");
  end

  // Sensor input pipeline: S1 is the capture register, S2 the edge-detect reference.
  logic       vsync_s1_q, vsync_s2_q;
  logic       href_s1_q, href_s2_q;
  logic [7:0] data_s1_q, data_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_s1_q <= 1'b0;
      vsync_s2_q <= 1'b0;
      href_s1_q  <= 1'b0;
      href_s2_q  <= 1'b0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
    end else begin
      vsync_s1_q <= cmos_vsync;
      vsync_s2_q <= vsync_s1_q;
      href_s1_q  <= cmos_href;
      href_s2_q  <= href_s1_q;
      data_s1_q  <= cmos_data;
      data_s2_q  <= data_s1_q;
    end
  end

  logic vs_fall, vs_rise;
  assign vs_fall = vsync_s2_q & ~vsync_s1_q;
  assign vs_rise = ~vsync_s2_q & vsync_s1_q;

  // Capture FSM.
  cmos_state_e         state_q, state_d;
  logic [SkipCntW-1:0] skip_cnt_q, skip_cnt_d;
  logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
  logic                skip_done;

  assign skip_done = 32'(skip_cnt_q) >= SKIP_FRAMES;

  always_comb begin
    state_d     = state_q;
    skip_cnt_d  = skip_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (!init_done) begin
      state_d    = StWaitInit;
      skip_cnt_d = '0;
    end else begin
      unique case (state_q)
        StWaitInit: state_d = StWaitVs;
        StWaitVs: begin
          if (vs_fall) begin
            state_d = skip_done ? StActive : StSkip;
          end
        end
        StSkip: begin
          if (vs_rise) begin
            state_d    = StWaitVs;
            skip_cnt_d = skip_cnt_q + SkipCntW'(1);
          end
        end
        StActive: begin
          if (vs_rise) begin
            state_d     = StWaitVs;
            frame_cnt_d = frame_cnt_q + FrameCntW'(1);
          end
        end
        default: state_d = StWaitInit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StWaitInit;
      skip_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Byte packing works on the S2 byte so it lines up with the S1/S2 edge detectors:
  // the cycle href_s2 & ~href_s1 is seen is the cycle the line's last byte is packed.
  logic        phase_q, phase_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        pix_we_q, pix_we_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        word_now;

  assign word_now = href_s2_q & phase_q & (state_q == StActive);

  always_comb begin
    phase_d    = href_s2_q ? ~phase_q : 1'b0;
    hi_byte_d  = hi_byte_q;
    pix_data_d = pix_data_q;
    pix_we_d   = 1'b0;
    if (href_s2_q && !phase_q) begin
      hi_byte_d = data_s2_q;
    end
    // Losing init suppresses a word still in flight.
    if (word_now && init_done) begin
      pix_we_d   = 1'b1;
      pix_data_d = {hi_byte_q, data_s2_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= 1'b0;
      hi_byte_q  <= '0;
      pix_we_q   <= 1'b0;
      pix_data_q <= '0;
    end else begin
      phase_q    <= phase_d;
      hi_byte_q  <= hi_byte_d;
      pix_we_q   <= pix_we_d;
      pix_data_q <= pix_data_d;
    end
  end

  assign pix_we      = pix_we_q;
  assign pix_data    = pix_data_q;
  assign frame_valid = (state_q == StActive);
  assign frame_cnt   = frame_cnt_q;

`ifdef CMOS_FRAME_CHECK_EN
  logic line_end, frame_end;
  assign line_end  = href_s2_q & ~href_s1_q;
  assign frame_end = (state_q == StActive) & vs_rise;

  cmos_geom_check #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_geom_check (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (~init_done),
    .active_i   (state_q == StActive),
    .word_i     (word_now),
    .line_end_i (line_end),
    .odd_i      (~phase_q),
    .frame_end_i(frame_end),
    .geom_err_o (geom_err)
  );
`else
  assign geom_err = 1'b0;
`endif

endmodule
